// File: rtl/multi_tick_gen.sv
// N-channel programmable tick / square-wave generator with per-channel divisor, mode and enable.
// Define MULTI_TICK_GEN_CASCADE_EN to let channel k>0 count channel k-1's ticks instead of mclk.
module multi_tick_gen #(
    parameter int NCH = 4,
    parameter int CW = 24,
    parameter logic [NCH*CW-1:0] RST_DIV = {24'd20, 24'd10000000, 24'd1000000, 24'd100000},
    parameter logic [NCH-1:0] RST_MODE = '0,
    localparam int WW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic          mclk,
    input  logic          clr,
    input  logic [NCH-1:0] en,
    input  logic          wr_en,
    input  logic [WW-1:0] wr_ch,
    input  logic [CW-1:0] wr_div,
    input  logic          wr_mode,
    input  logic [NCH-1:0] casc,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq,
    output logic [NCH-1:0] armed
);

    logic [CW-1:0]  div  [NCH];
    logic [CW-1:0]  cnt  [NCH];
    logic [CW-1:0]  last [NCH];
    logic [NCH-1:0] mode;
    logic [NCH-1:0] step;
    logic [NCH-1:0] adv;
    logic [NCH-1:0] term;
    logic [NCH-1:0] wr_hit;
    logic           unused_casc;

`ifdef MULTI_TICK_GEN_CASCADE_EN
    // A cascaded stage advances on the upstream terminal-count strobe, lagging it by one cycle.
    always_comb begin
        step = '1;
        for (int unsigned k = 1; k < NCH; k++) begin
            if (casc[k]) step[k] = tick[k-1];
        end
    end
    assign unused_casc = casc[0];
`else
    assign step        = '1;
    assign unused_casc = ^casc;
`endif

    always_comb begin
        adv    = '0;
        term   = '0;
        wr_hit = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            // div of 0 behaves as 1, so the terminal count is 0 in both cases.
            last[k]   = (div[k] == '0) ? '0 : div[k] - CW'(1);
            term[k]   = (cnt[k] == last[k]);
            adv[k]    = en[k] & armed[k] & step[k];
            wr_hit[k] = wr_en && (wr_ch == WW'(k));
        end
    end

    always_ff @(posedge mclk) begin
        if (clr) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                div[k] <= RST_DIV[k*CW +: CW];
                cnt[k] <= '0;
            end
            mode  <= RST_MODE;
            tick  <= '0;
            sq    <= '0;
            armed <= '1;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (wr_hit[k]) begin
                    div[k]   <= wr_div;
                    mode[k]  <= wr_mode;
                    cnt[k]   <= '0;
                    tick[k]  <= 1'b0;
                    sq[k]    <= 1'b0;
                    armed[k] <= 1'b1;
                end else if (adv[k]) begin
                    if (term[k]) begin
                        cnt[k]  <= '0;
                        tick[k] <= 1'b1;
                        sq[k]   <= ~sq[k];
                        if (mode[k]) armed[k] <= 1'b0;
                    end else begin
                        cnt[k]  <= cnt[k] + CW'(1);
                        tick[k] <= 1'b0;
                    end
                end else begin
                    tick[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed self-checking bench for multi_tick_gen: default 4-channel instance plus a
// 3-channel instance used to exercise out-of-range channel writes.
module tb_multi_tick_gen;

    logic        mclk;
    logic        clr;
    logic [3:0]  en;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [23:0] wr_div;
    logic        wr_mode;
    logic [3:0]  casc;
    logic [3:0]  tick;
    logic [3:0]  sq;
    logic [3:0]  armed;

    logic        s_clr;
    logic [2:0]  s_en;
    logic        s_wr_en;
    logic [1:0]  s_wr_ch;
    logic [7:0]  s_wr_div;
    logic        s_wr_mode;
    logic [2:0]  s_casc;
    logic [2:0]  s_tick;
    logic [2:0]  s_sq;
    logic [2:0]  s_armed;

    int n_cmp;
    int n_err;

    multi_tick_gen dut (
        .mclk(mclk), .clr(clr), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_div(wr_div), .wr_mode(wr_mode), .casc(casc),
        .tick(tick), .sq(sq), .armed(armed)
    );

    multi_tick_gen #(
        .NCH(3),
        .CW(8),
        .RST_DIV({8'd4, 8'd3, 8'd2}),
        .RST_MODE(3'b000)
    ) u_small (
        .mclk(mclk), .clr(s_clr), .en(s_en), .wr_en(s_wr_en), .wr_ch(s_wr_ch),
        .wr_div(s_wr_div), .wr_mode(s_wr_mode), .casc(s_casc),
        .tick(s_tick), .sq(s_sq), .armed(s_armed)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic wr_cfg(input logic [1:0] ch, input logic [23:0] d, input logic m);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_div  = d;
        wr_mode = m;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp4;
        clr = 1'b1;
        en  = 4'hF;
        step();
        step();
        n_cmp++;
        if (tick !== 4'h0) begin n_err++; $display("FAIL reset_tick got=%h exp=0", tick); end
        n_cmp++;
        if (sq !== 4'h0) begin n_err++; $display("FAIL reset_sq got=%h exp=0", sq); end
        n_cmp++;
        if (armed !== 4'hF) begin n_err++; $display("FAIL reset_armed got=%h exp=F", armed); end
        clr = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            step();
            exp4 = (i % 20 == 0) ? 4'b1000 : 4'b0000;
            n_cmp++;
            if (tick !== exp4) begin n_err++; $display("FAIL default_tick cyc=%0d got=%h exp=%h", i, tick, exp4); end
            n_cmp++;
            if (sq[3] !== 1'((i / 20) % 2)) begin n_err++; $display("FAIL default_sq3 cyc=%0d got=%b exp=%b", i, sq[3], 1'((i / 20) % 2)); end
        end
        n_cmp++;
        if (armed !== 4'hF) begin n_err++; $display("FAIL default_armed got=%h exp=F", armed); end
    endtask

    task automatic test_div_write();
        wr_cfg(2'd2, 24'd5, 1'b0);
        n_cmp++;
        if (sq[2] !== 1'b0 || tick[2] !== 1'b0) begin n_err++; $display("FAIL wr_clear sq2=%b tick2=%b exp=0/0", sq[2], tick[2]); end
        for (int i = 1; i <= 27; i++) begin
            step();
            n_cmp++;
            if (tick[2] !== (i % 5 == 0)) begin n_err++; $display("FAIL div5_tick cyc=%0d got=%b exp=%b", i, tick[2], (i % 5 == 0)); end
            n_cmp++;
            if (sq[2] !== 1'((i / 5) % 2)) begin n_err++; $display("FAIL div5_sq cyc=%0d got=%b exp=%b", i, sq[2], 1'((i / 5) % 2)); end
        end
        wr_cfg(2'd2, 24'd5, 1'b0);
        n_cmp++;
        if (sq[2] !== 1'b0) begin n_err++; $display("FAIL midcount_wr_sq got=%b exp=0", sq[2]); end
        for (int i = 1; i <= 5; i++) begin
            step();
            n_cmp++;
            if (tick[2] !== (i == 5)) begin n_err++; $display("FAIL rewr_tick cyc=%0d got=%b exp=%b", i, tick[2], (i == 5)); end
        end
    endtask

    task automatic test_one_shot();
        wr_cfg(2'd1, 24'd3, 1'b1);
        n_cmp++;
        if (armed[1] !== 1'b1) begin n_err++; $display("FAIL oneshot_armed0 got=%b exp=1", armed[1]); end
        for (int i = 1; i <= 100; i++) begin
            step();
            n_cmp++;
            if (tick[1] !== (i == 3)) begin n_err++; $display("FAIL oneshot_tick cyc=%0d got=%b exp=%b", i, tick[1], (i == 3)); end
            n_cmp++;
            if (armed[1] !== (i < 3)) begin n_err++; $display("FAIL oneshot_armed cyc=%0d got=%b exp=%b", i, armed[1], (i < 3)); end
            n_cmp++;
            if (sq[1] !== (i >= 3)) begin n_err++; $display("FAIL oneshot_sq cyc=%0d got=%b exp=%b", i, sq[1], (i >= 3)); end
        end
        wr_cfg(2'd1, 24'd3, 1'b1);
        n_cmp++;
        if (armed[1] !== 1'b1 || sq[1] !== 1'b0) begin n_err++; $display("FAIL rearm armed=%b sq=%b exp=1/0", armed[1], sq[1]); end
        for (int i = 1; i <= 3; i++) begin
            step();
            n_cmp++;
            if (tick[1] !== (i == 3)) begin n_err++; $display("FAIL rearm_tick cyc=%0d got=%b exp=%b", i, tick[1], (i == 3)); end
        end
    endtask

    task automatic test_div_zero_pause();
        wr_cfg(2'd3, 24'd0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step();
            n_cmp++;
            if (tick[3] !== 1'b1) begin n_err++; $display("FAIL div0_tick cyc=%0d got=%b exp=1", i, tick[3]); end
            n_cmp++;
            if (sq[3] !== 1'(i % 2)) begin n_err++; $display("FAIL div0_sq cyc=%0d got=%b exp=%b", i, sq[3], 1'(i % 2)); end
        end
        wr_cfg(2'd3, 24'd4, 1'b0);
        step();
        step();
        en[3] = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            n_cmp++;
            if (tick[3] !== 1'b0 || sq[3] !== 1'b0) begin n_err++; $display("FAIL pause cyc=%0d tick=%b sq=%b exp=0/0", i, tick[3], sq[3]); end
        end
        en[3] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_cmp++;
            if (tick[3] !== (i == 2 || i == 6)) begin n_err++; $display("FAIL resume_tick cyc=%0d got=%b exp=%b", i, tick[3], (i == 2 || i == 6)); end
        end
    endtask

    task automatic test_out_of_range();
        logic [2:0] exp3;
        s_clr = 1'b1;
        s_en  = 3'b111;
        step();
        s_clr     = 1'b0;
        s_wr_en   = 1'b1;
        s_wr_ch   = 2'd3;
        s_wr_div  = 8'd1;
        s_wr_mode = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            exp3 = {(i % 4 == 0), (i % 3 == 0), (i % 2 == 0)};
            n_cmp++;
            if (s_tick !== exp3) begin n_err++; $display("FAIL oor_tick cyc=%0d got=%b exp=%b", i, s_tick, exp3); end
            n_cmp++;
            if (s_armed !== 3'b111) begin n_err++; $display("FAIL oor_armed cyc=%0d got=%b exp=111", i, s_armed); end
        end
        s_wr_en = 1'b0;
    endtask

    task automatic test_clr_mid();
        logic [3:0] exp4;
        en = 4'hF;
        step();
        step();
        step();
        clr     = 1'b1;
        wr_en   = 1'b1;
        wr_ch   = 2'd3;
        wr_div  = 24'd7;
        wr_mode = 1'b1;
        step();
        n_cmp++;
        if (tick !== 4'h0 || sq !== 4'h0 || armed !== 4'hF) begin
            n_err++; $display("FAIL clr_outputs tick=%h sq=%h armed=%h exp=0/0/F", tick, sq, armed);
        end
        clr   = 1'b0;
        wr_en = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            exp4 = (i % 20 == 0) ? 4'b1000 : 4'b0000;
            n_cmp++;
            if (tick !== exp4) begin n_err++; $display("FAIL clr_div_restore cyc=%0d got=%h exp=%h", i, tick, exp4); end
        end
    endtask

    task automatic test_cascade();
        logic exp1;
        en = 4'h0;
        wr_cfg(2'd0, 24'd4, 1'b0);
        wr_cfg(2'd1, 24'd3, 1'b0);
        casc = 4'b0010;
        en   = 4'b0011;
        for (int i = 1; i <= 40; i++) begin
            step();
`ifdef MULTI_TICK_GEN_CASCADE_EN
            exp1 = (i > 1) && (i % 12 == 1);
`else
            exp1 = (i % 3 == 0);
`endif
            n_cmp++;
            if (tick[0] !== (i % 4 == 0)) begin n_err++; $display("FAIL casc_tick0 cyc=%0d got=%b exp=%b", i, tick[0], (i % 4 == 0)); end
            n_cmp++;
            if (tick[1] !== exp1) begin n_err++; $display("FAIL casc_tick1 cyc=%0d got=%b exp=%b", i, tick[1], exp1); end
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        clr       = 1'b1;
        en        = 4'h0;
        wr_en     = 1'b0;
        wr_ch     = 2'd0;
        wr_div    = 24'd0;
        wr_mode   = 1'b0;
        casc      = 4'h0;
        s_clr     = 1'b1;
        s_en      = 3'b000;
        s_wr_en   = 1'b0;
        s_wr_ch   = 2'd0;
        s_wr_div  = 8'd0;
        s_wr_mode = 1'b0;
        s_casc    = 3'b000;
        test_reset();
        test_div_write();
        test_one_shot();
        test_div_zero_pause();
        test_out_of_range();
        test_clr_mid();
        test_cascade();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
